// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the 5-stage pipeline register chain.
// Detects load-use hazards and taken-branch redirects, holds decode while a
// multi-cycle MULT/DIV occupies EX, and counts cycles in which the PC is held.
// idex_bubble drives the ID/EX sync reset, which loads the NOOP ALU op 5'b01101.
module hazard_ctrl #(
   parameter int MULDIV_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_muldiv,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             branch_taken,
   input  logic             stat_clr,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             muldiv_start,
   output logic             muldiv_busy,
   output logic [CNT_W-1:0] stall_count
);

   localparam int CW = $clog2(MULDIV_CYCLES) + 1;

   typedef enum logic {
      RUN    = 1'b0,
      MDBUSY = 1'b1
   } state_t;

   state_t          st;
   state_t          st_next;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_next;
   logic            ld_haz;

   // A load in EX writing a register that the ID instruction reads; r0 never hazards
   assign ld_haz = ex_memread && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

   // State register and MULT/DIV occupancy down-counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st  <= RUN;
         cnt <= '0;
      end else begin
         st  <= st_next;
         cnt <= cnt_next;
      end
   end

   // Next state: a MULT/DIV issues only when no redirect or load-use stall outranks it
   always_comb begin
      st_next  = RUN;
      cnt_next = '0;
      case (st)
         RUN: begin
            if (!branch_taken && !ld_haz && id_muldiv) begin
               st_next  = MDBUSY;
               cnt_next = CW'(MULDIV_CYCLES - 1);
            end
         end
         MDBUSY: begin
            if (cnt <= CW'(1)) begin
               st_next  = RUN;
               cnt_next = '0;
            end else begin
               st_next  = MDBUSY;
               cnt_next = cnt - CW'(1);
            end
         end
         default: begin
            st_next  = RUN;
            cnt_next = '0;
         end
      endcase
   end

   // Outputs: combinational from state and inputs, forced to a safe squash during reset
   always_comb begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      muldiv_start = 1'b0;
      muldiv_busy  = 1'b0;
      if (!reset) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         case (st)
            RUN: begin
               if (branch_taken) begin
                  pc_we       = 1'b1;
                  ifid_we     = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (ld_haz) begin
                  idex_bubble = 1'b1;
               end else if (id_muldiv) begin
                  pc_we        = 1'b1;
                  ifid_we      = 1'b1;
                  muldiv_start = 1'b1;
               end else begin
                  pc_we   = 1'b1;
                  ifid_we = 1'b1;
               end
            end
            MDBUSY: begin
               idex_bubble = 1'b1;
               muldiv_busy = 1'b1;
            end
            default: begin
               idex_bubble = 1'b1;
            end
         endcase
      end
   end

   // Saturating count of cycles with the PC held; clear has priority over counting
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
      end else if (stat_clr) begin
         stall_count <= '0;
      end else if (!pc_we && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a
// behavioural model built from the pipeline stall/flush rules.
module tb_hazard_ctrl;

   localparam int MC      = 4;
   localparam int SMALL_W = 3;

   logic        clock;
   logic        reset;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        id_muldiv;
   logic [4:0]  ex_rd;
   logic        ex_memread;
   logic        branch_taken;
   logic        stat_clr;

   logic        pc_we, ifid_we, ifid_flush, idex_bubble, muldiv_start, muldiv_busy;
   logic [15:0] stall_count;

   logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble, s_muldiv_start, s_muldiv_busy;
   logic [SMALL_W-1:0] s_stall_count;

   int asserts_run;
   int fails;

   // model state: MDBUSY cycles still to come and the two saturating counts
   int     busy_left;
   longint stall_big;
   longint stall_small;

   // expected outputs for the current cycle
   logic e_pc, e_ifid, e_flush, e_bubble, e_start, e_busy;

   hazard_ctrl #(.MULDIV_CYCLES(MC), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_muldiv(id_muldiv), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .branch_taken(branch_taken), .stat_clr(stat_clr),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .muldiv_start(muldiv_start),
      .muldiv_busy(muldiv_busy), .stall_count(stall_count)
   );

   hazard_ctrl #(.MULDIV_CYCLES(MC), .CNT_W(SMALL_W)) dut_small (
      .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_muldiv(id_muldiv), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .branch_taken(branch_taken), .stat_clr(stat_clr),
      .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
      .idex_bubble(s_idex_bubble), .muldiv_start(s_muldiv_start),
      .muldiv_busy(s_muldiv_busy), .stall_count(s_stall_count)
   );

   // free-running clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      asserts_run++;
      assert (obs === expv) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // derive expected outputs from the pipeline rules
   task automatic computeExpected();
      logic haz;
      haz = ex_memread && (ex_rd != 0) &&
            ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
      {e_pc, e_ifid, e_flush, e_bubble, e_start, e_busy} = 6'b000000;
      if (!reset) begin
         e_flush = 1; e_bubble = 1;
      end else if (busy_left > 0) begin
         e_bubble = 1; e_busy = 1;
      end else if (branch_taken) begin
         e_pc = 1; e_ifid = 1; e_flush = 1; e_bubble = 1;
      end else if (haz) begin
         e_bubble = 1;
      end else if (id_muldiv) begin
         e_pc = 1; e_ifid = 1; e_start = 1;
      end else begin
         e_pc = 1; e_ifid = 1;
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urt, input logic md, input logic [4:0] rd,
                                input logic mr, input logic br, input logic clr);
      @(negedge clock);
      reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_muldiv = md;
      ex_rd = rd; ex_memread = mr; branch_taken = br; stat_clr = clr;
      if (!rst) begin
         busy_left = 0; stall_big = 0; stall_small = 0;
      end
      #2;
      computeExpected();
      checkOutput("pc_we",        32'(pc_we),        32'(e_pc));
      checkOutput("ifid_we",      32'(ifid_we),      32'(e_ifid));
      checkOutput("ifid_flush",   32'(ifid_flush),   32'(e_flush));
      checkOutput("idex_bubble",  32'(idex_bubble),  32'(e_bubble));
      checkOutput("muldiv_start", 32'(muldiv_start), 32'(e_start));
      checkOutput("muldiv_busy",  32'(muldiv_busy),  32'(e_busy));
      checkOutput("stall_count",  32'(stall_count),  32'(stall_big));
      checkOutput("small_stall_count", 32'(s_stall_count), 32'(stall_small));
      @(posedge clock);
      if (rst) begin
         if (clr) begin
            stall_big = 0; stall_small = 0;
         end else if (!e_pc) begin
            if (stall_big < 65535) stall_big++;
            if (stall_small < (2**SMALL_W - 1)) stall_small++;
         end
         if (busy_left > 0) busy_left--;
         else if (e_start) busy_left = MC - 1;
      end
   endtask

   task automatic idle();
      applyStimulus(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0);
   endtask

   initial begin
      asserts_run = 0; fails = 0;
      busy_left = 0; stall_big = 0; stall_small = 0;
      reset = 1'b0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_muldiv = 0;
      ex_rd = 0; ex_memread = 0; branch_taken = 0; stat_clr = 0;

      // T1: reset held low, then first clean cycle runs
      repeat (3) applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0);
      idle();
      checkOutput("t1_count_zero", 32'(stall_count), 32'd0);

      // T2: load-use on rs, then r0 and an unused rt produce no stall
      applyStimulus(1, 5'd8, 5'd3, 1, 0, 5'd8, 1, 0, 0);
      checkOutput("t2_pc_held", 32'(pc_we), 32'd0);
      idle();
      checkOutput("t2_count_one", 32'(stall_count), 32'd1);
      applyStimulus(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0);
      applyStimulus(1, 5'd1, 5'd8, 0, 0, 5'd8, 1, 0, 0);
      checkOutput("t2_rt_unused", 32'(pc_we), 32'd1);
      applyStimulus(1, 5'd1, 5'd8, 1, 0, 5'd8, 1, 0, 0);

      // T3: MULT/DIV occupies EX for three extra cycles
      applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 0);
      checkOutput("t3_start", 32'(muldiv_start), 32'd1);
      repeat (3) begin
         idle();
         checkOutput("t3_busy", 32'(muldiv_busy), 32'd1);
      end
      idle();
      checkOutput("t3_back_to_run", 32'(pc_we), 32'd1);
      checkOutput("t3_count", 32'(stall_count), 32'd5);

      // T4: redirect outranks load-use and MULT/DIV
      applyStimulus(1, 5'd5, 5'd2, 1, 1, 5'd5, 1, 1, 0);
      checkOutput("t4_no_start", 32'(muldiv_start), 32'd0);
      idle();
      checkOutput("t4_still_run", 32'(muldiv_busy), 32'd0);

      // T5: reset in the second MDBUSY cycle aborts the operation
      applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 0);
      idle();
      applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0);
      checkOutput("t5_busy_drop", 32'(muldiv_busy), 32'd0);
      idle();
      checkOutput("t5_run_after", 32'(pc_we), 32'd1);

      // T6: the narrow counter saturates, then clear wins during a stall
      repeat (9) applyStimulus(1, 5'd9, 5'd2, 1, 0, 5'd9, 1, 0, 0);
      checkOutput("t6_saturated", 32'(s_stall_count), 32'd7);
      applyStimulus(1, 5'd9, 5'd2, 1, 0, 5'd9, 1, 0, 1);
      idle();
      checkOutput("t6_cleared", 32'(s_stall_count), 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 99) >= 3),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 15),
                       5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 40),
                       ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", asserts_run, fails);
      $finish;
   end

endmodule
